dual_slope_ctrl: RTL and testbench

Dual-slope conversion sequencer inside `digital_top`, directly upstream of `analog_top`. It drives the AFE controls `afe_sel`, `ref_sign`, `afe_reset` and `range_sel`, and consumes the AFE status `comp`, `sat_hi`, `sat_lo` and `ref_ok`. It runs the sequence reset → auto-zero → fixed integrate → timed deintegrate. It produces a signed count, an overrange flag and an autorange update for the SPI readout logic.

---
 rtl/dual_slope_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_dual_slope_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/dual_slope_ctrl.sv
// Dual-slope conversion sequencer.
//
// Runs reset -> auto-zero -> wait for reference -> fixed integrate -> timed deintegrate
// and reports a signed count, an overrange flag and an autorange update.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   start_i             conversion request, only honoured in IDLE
//   abort_i             cancel the running conversion and restart from RESET
//   comp_i              comparator (1: Vint >= 0), asynchronous
//   sat_hi_i, sat_lo_i  integrator saturated at the +/- rail
//   ref_ok_i            reference settled
//   afe_sel_o           AFE input select: 00 AZ, 01 VIN, 10 +VREF, 11 -VREF
//   ref_sign_o          deintegrate polarity (1: -VREF)
//   afe_reset_o         integrator discharge
//   range_sel_o         autorange code
//   busy_o, done_o      not-idle flag, one-cycle result strobe
//   result_o            deintegrate count (all-ones on overrange)
//   result_neg_o        input polarity (1: negative)
//   overrange_o         last result was overrange
//
// The phase counter is CNT_W wide and is shared by every timed phase, so RST_CYC, T_AZ,
// T_INT and DEINT_MAX must all fit in CNT_W bits.
module dual_slope_ctrl #(
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned RST_CYC   = 4,
  parameter int unsigned T_AZ      = 64,
  parameter int unsigned T_INT     = 1000,
  parameter int unsigned DEINT_MAX = 2000,
  parameter int unsigned UNDER_TH  = 180
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic             comp_i,
  input  logic             sat_hi_i,
  input  logic             sat_lo_i,
  input  logic             ref_ok_i,
  output logic [1:0]       afe_sel_o,
  output logic             ref_sign_o,
  output logic             afe_reset_o,
  output logic [2:0]       range_sel_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] result_o,
  output logic             result_neg_o,
  output logic             overrange_o
);

  typedef enum logic [2:0] {
    StIdle, StReset, StAz, StWaitRef, StInteg, StDeint, StDone
  } state_e;

  localparam logic [CNT_W-1:0] RstLast  = CNT_W'(RST_CYC - 1);
  localparam logic [CNT_W-1:0] AzLast   = CNT_W'(T_AZ - 1);
  localparam logic [CNT_W-1:0] IntLast  = CNT_W'(T_INT - 1);
  localparam logic [CNT_W-1:0] DeintMax = CNT_W'(DEINT_MAX);
  localparam logic [CNT_W-1:0] UnderTh  = CNT_W'(UNDER_TH);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_inc;
  logic [1:0]       comp_sync_q, sat_hi_sync_q, sat_lo_sync_q, ref_ok_sync_q;
  logic             pol_q;       // comparator level captured at the end of INTEG
  logic             sat_seen_q;  // saturation observed during the current INTEG
  logic             ovr_q;       // overrange verdict of the current conversion

  logic [1:0]       afe_sel_q;
  logic             ref_sign_q, afe_reset_q, busy_q, done_q, result_neg_q, overrange_q;
  logic [2:0]       range_sel_q;
  logic [CNT_W-1:0] result_q;

  logic comp_s, sat_now, ref_ok_s, abort_hit;

  assign comp_s   = comp_sync_q[1];
  assign ref_ok_s = ref_ok_sync_q[1];
  assign sat_now  = sat_hi_sync_q[1] | sat_lo_sync_q[1];
  assign cnt_inc  = cnt_q + CNT_W'(1);
  // RESET is not restarted by abort, and DONE has already committed its result.
  assign abort_hit = abort_i && (state_q != StIdle) && (state_q != StReset)
                     && (state_q != StDone);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      comp_sync_q   <= 2'b00;
      sat_hi_sync_q <= 2'b00;
      sat_lo_sync_q <= 2'b00;
      ref_ok_sync_q <= 2'b00;
      state_q       <= StIdle;
      cnt_q         <= '0;
      pol_q         <= 1'b0;
      sat_seen_q    <= 1'b0;
      ovr_q         <= 1'b0;
      afe_sel_q     <= 2'b00;
      ref_sign_q    <= 1'b0;
      afe_reset_q   <= 1'b0;
      range_sel_q   <= 3'd7;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      result_q      <= '0;
      result_neg_q  <= 1'b0;
      overrange_q   <= 1'b0;
    end else begin
      comp_sync_q   <= {comp_sync_q[0], comp_i};
      sat_hi_sync_q <= {sat_hi_sync_q[0], sat_hi_i};
      sat_lo_sync_q <= {sat_lo_sync_q[0], sat_lo_i};
      ref_ok_sync_q <= {ref_ok_sync_q[0], ref_ok_i};
      done_q        <= 1'b0;

      if (abort_hit) begin
        state_q     <= StReset;
        cnt_q       <= '0;
        afe_reset_q <= 1'b1;
        afe_sel_q   <= 2'b00;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (start_i) begin
              state_q     <= StReset;
              cnt_q       <= '0;
              afe_reset_q <= 1'b1;
              afe_sel_q   <= 2'b00;
              busy_q      <= 1'b1;
            end
          end
          StReset: begin
            if (cnt_q == RstLast) begin
              state_q     <= StAz;
              cnt_q       <= '0;
              afe_reset_q <= 1'b0;
            end else begin
              cnt_q <= cnt_inc;
            end
          end
          StAz: begin
            if (cnt_q == AzLast) begin
              state_q <= StWaitRef;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_inc;
            end
          end
          StWaitRef: begin
            if (ref_ok_s) begin
              state_q    <= StInteg;
              cnt_q      <= '0;
              afe_sel_q  <= 2'b01;
              sat_seen_q <= 1'b0;
            end
          end
          StInteg: begin
            if (sat_now) sat_seen_q <= 1'b1;
            if (cnt_q == IntLast) begin
              // Deintegrate against the reference opposite to the integrated sign.
              pol_q      <= comp_s;
              ref_sign_q <= comp_s;
              cnt_q      <= '0;
              if (sat_seen_q || sat_now) begin
                state_q   <= StDone;
                ovr_q     <= 1'b1;
                afe_sel_q <= 2'b00;
              end else begin
                state_q   <= StDeint;
                ovr_q     <= 1'b0;
                afe_sel_q <= {1'b1, comp_s};
              end
            end else begin
              cnt_q <= cnt_inc;
            end
          end
          StDeint: begin
            // cnt_inc is the number of DEINT cycles including this one; it becomes the result.
            cnt_q <= cnt_inc;
            if (cnt_inc == DeintMax) begin
              state_q   <= StDone;
              ovr_q     <= 1'b1;
              afe_sel_q <= 2'b00;
            end else if (comp_s != pol_q) begin
              state_q   <= StDone;
              ovr_q     <= 1'b0;
              afe_sel_q <= 2'b00;
            end
          end
          StDone: begin
            state_q      <= StIdle;
            busy_q       <= 1'b0;
            done_q       <= 1'b1;
            result_q     <= ovr_q ? '1 : cnt_q;
            result_neg_q <= ~pol_q;
            overrange_q  <= ovr_q;
            if (ovr_q) begin
              if (range_sel_q != 3'd7) range_sel_q <= range_sel_q + 3'd1;
            end else if ((cnt_q < UnderTh) && (range_sel_q != 3'd0)) begin
              range_sel_q <= range_sel_q - 3'd1;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign afe_sel_o    = afe_sel_q;
  assign ref_sign_o   = ref_sign_q;
  assign afe_reset_o  = afe_reset_q;
  assign range_sel_o  = range_sel_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign result_o     = result_q;
  assign result_neg_o = result_neg_q;
  assign overrange_o  = overrange_q;

endmodule

// File: tb/tb_dual_slope_ctrl.sv
// Self-checking bench for dual_slope_ctrl: directed steps followed by random conversions,
// each predicted cycle by cycle from phase lengths and the autorange rules.
module tb_dual_slope_ctrl;

  localparam int CNT_W     = 16;
  localparam int RST_CYC   = 2;
  localparam int T_AZ      = 4;
  localparam int T_INT     = 100;
  localparam int DEINT_MAX = 200;
  localparam int UNDER_TH  = 20;
  // Offset of DEINT entry from RESET entry (one WAIT_REF cycle with ref_ok high).
  localparam int EI        = RST_CYC + T_AZ + 1 + T_INT;
  localparam int INT0      = RST_CYC + T_AZ + 1;
  localparam int NEVER     = 100000;

  logic             clk = 1'b0;
  logic             rst, start, abort, comp, sat_hi, sat_lo, ref_ok;
  logic [1:0]       afe_sel;
  logic             ref_sign, afe_reset, busy, done, result_neg, overrange;
  logic [2:0]       range_sel;
  logic [CNT_W-1:0] result;

  int errors = 0;
  int checks = 0;

  // Reference model of the committed outputs.
  int m_range = 7;
  int m_res   = 0;
  int m_neg   = 0;
  int m_ovr   = 0;

  dual_slope_ctrl #(
    .CNT_W    (CNT_W),
    .RST_CYC  (RST_CYC),
    .T_AZ     (T_AZ),
    .T_INT    (T_INT),
    .DEINT_MAX(DEINT_MAX),
    .UNDER_TH (UNDER_TH)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .abort_i     (abort),
    .comp_i      (comp),
    .sat_hi_i    (sat_hi),
    .sat_lo_i    (sat_lo),
    .ref_ok_i    (ref_ok),
    .afe_sel_o   (afe_sel),
    .ref_sign_o  (ref_sign),
    .afe_reset_o (afe_reset),
    .range_sel_o (range_sel),
    .busy_o      (busy),
    .done_o      (done),
    .result_o    (result),
    .result_neg_o(result_neg),
    .overrange_o (overrange)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int t, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s (t=%0d): got %0h, expected %0h", tag, t, obs, exp);
    end
  endtask

  task automatic chk_results(input int t);
    chk("result_o", t, result, m_res);
    chk("result_neg_o", t, result_neg, m_neg);
    chk("overrange_o", t, overrange, m_ovr);
    chk("range_sel_o", t, range_sel, m_range);
  endtask

  // One conversion, t counted in cycles from the edge that enters RESET.
  // k: cycles into DEINT at which comp flips; sat_kind 0 none, 1 hi, 2 lo.
  // abort_t: abort driven at t and the task returns (conversion restarts).
  // abort_ign_t / start_t: pulses expected to be ignored (-2 = DONE cycle, -3 = first IDLE).
  task automatic conv(input int pol, input int k, input int sat_kind, input int sat_pos,
                      input int abort_t, input int abort_ign_t, input int start_t,
                      input bit need_start);
    int d, ovr, res, a_ign, s_t, e_sel, e_rst, e_busy, e_done;
    if (sat_kind != 0) begin
      d = 0; ovr = 1;
    end else if (k + 3 >= DEINT_MAX) begin
      d = DEINT_MAX; ovr = 1;
    end else begin
      d = k + 3; ovr = 0;
    end
    res   = ovr ? 65535 : d;
    a_ign = (abort_ign_t == -2) ? EI + d : (abort_ign_t == -3) ? EI + d + 1 : abort_ign_t;
    s_t   = (start_t == -2) ? EI + d : start_t;
    if (need_start) begin
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    for (int t = 0; t <= EI + d + 2; t++) begin
      if (t < RST_CYC) begin
        e_sel = 0; e_rst = 1; e_busy = 1; e_done = 0;
      end else if (t < INT0) begin
        e_sel = 0; e_rst = 0; e_busy = 1; e_done = 0;
      end else if (t < EI) begin
        e_sel = 1; e_rst = 0; e_busy = 1; e_done = 0;
      end else if (t < EI + d) begin
        e_sel = pol ? 3 : 2; e_rst = 0; e_busy = 1; e_done = 0;
      end else if (t == EI + d) begin
        e_sel = 0; e_rst = 0; e_busy = 1; e_done = 0;
      end else if (t == EI + d + 1) begin
        e_sel = 0; e_rst = 0; e_busy = 0; e_done = 1;
      end else begin
        e_sel = 0; e_rst = 0; e_busy = 0; e_done = 0;
      end
      chk("afe_sel_o", t, afe_sel, e_sel);
      chk("afe_reset_o", t, afe_reset, e_rst);
      chk("busy_o", t, busy, e_busy);
      chk("done_o", t, done, e_done);
      if (t >= EI && t < EI + d) chk("ref_sign_o", t, ref_sign, pol);
      if (t == EI + d + 1) begin
        if (ovr != 0) begin
          if (m_range < 7) m_range++;
        end else if (res < UNDER_TH && m_range > 0) begin
          m_range--;
        end
        m_res = res; m_neg = (pol == 0); m_ovr = ovr;
      end
      if (t == 0 || t == EI + d || t == EI + d + 1) chk_results(t);
      comp   = (sat_kind == 0 && t >= EI + k) ? (pol == 0) : (pol != 0);
      sat_hi = (sat_kind == 1 && t >= INT0 + sat_pos && t < INT0 + sat_pos + 3);
      sat_lo = (sat_kind == 2 && t >= INT0 + sat_pos && t < INT0 + sat_pos + 3);
      start  = (t == s_t);
      abort  = (t == abort_t) || (t == a_ign);
      @(posedge clk); #1;
      if (t == abort_t) begin
        abort = 1'b0; start = 1'b0;
        return;
      end
    end
    start = 1'b0; abort = 1'b0; sat_hi = 1'b0; sat_lo = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; comp = 1'b0;
    sat_hi = 1'b0; sat_lo = 1'b0; ref_ok = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst afe_sel_o", 0, afe_sel, 0);
    chk("rst ref_sign_o", 0, ref_sign, 0);
    chk("rst afe_reset_o", 0, afe_reset, 0);
    chk("rst busy_o", 0, busy, 0);
    chk("rst done_o", 0, done, 0);
    chk_results(0);
    rst = 1'b0;
    abort = 1'b1;  // ignored in IDLE
    repeat (4) @(posedge clk);
    #1;
    abort = 1'b0;
    chk("idle busy_o", 0, busy, 0);
    chk("idle afe_reset_o", 0, afe_reset, 0);

    // Positive and negative nominal, DEINT timeout and the DEINT_MAX boundary.
    conv(1, 50, 0, 0, -1, -1, -1, 1'b1);
    conv(0, 120, 0, 0, -1, -1, -1, 1'b1);
    conv(1, NEVER, 0, 0, -1, -1, -1, 1'b1);
    conv(0, DEINT_MAX - 4, 0, 0, -1, -1, -1, 1'b1);
    conv(1, DEINT_MAX - 3, 0, 0, -1, -1, -1, 1'b1);

    // Step down to range 5, then saturation on either rail steps back up.
    while (m_range > 5) conv(1, 7, 0, 0, -1, -1, -1, 1'b1);
    conv(1, 0, 1, 40, -1, -1, -1, 1'b1);
    conv(0, 0, 2, T_INT - 4, -1, -1, -1, 1'b1);
    conv(1, 0, 1, 0, -1, -1, -1, 1'b1);

    // Underrange walks down to 0 and holds there; overrange from 0 steps up.
    repeat (9) conv(0, 7, 0, 0, -1, -1, -1, 1'b1);
    conv(0, NEVER, 0, 0, -1, -1, -1, 1'b1);

    // Abort mid-DEINT, in INTEG and in AZ; each restart completes normally.
    conv(1, NEVER, 0, 0, EI + 50, -1, -1, 1'b1);
    conv(1, 47, 0, 0, -1, -1, -1, 1'b0);
    conv(0, NEVER, 0, 0, INT0 + 30, -1, -1, 1'b1);
    conv(0, 60, 0, 0, -1, -1, -1, 1'b0);
    conv(1, NEVER, 0, 0, RST_CYC + 1, -1, -1, 1'b1);
    conv(1, 5, 0, 0, -1, -1, -1, 1'b0);

    // Abort ignored in RESET, DONE and IDLE; start ignored while busy.
    conv(0, 30, 0, 0, -1, 0, -1, 1'b1);
    conv(1, 30, 0, 0, -1, -2, -1, 1'b1);
    conv(0, 30, 0, 0, -1, -3, -1, 1'b1);
    conv(1, 40, 0, 0, -1, -1, INT0 + 20, 1'b1);
    conv(0, 40, 0, 0, -1, -1, -2, 1'b1);

    // Random conversions.
    for (int i = 0; i < 20; i++) begin
      int r, kind, pos, pol, k, st;
      r    = $urandom_range(0, 5);
      kind = (r == 0) ? 1 : (r == 1) ? 2 : 0;
      pos  = $urandom_range(0, T_INT - 4);
      pol  = $urandom_range(0, 1);
      k    = $urandom_range(0, DEINT_MAX + 20);
      st   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, EI) : -1;
      conv(pol, k, kind, pos, -1, -1, st, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
